pipelined_adder: RTL and testbench

//   Parametrised pipelined adder/subtractor; successor to the fixed 8-bit ripple adder.

---
 rtl/pipelined_adder_if.sv | 37 +++
 rtl/pipelined_adder.sv | 121 ++++++++++++
 tb/tb_pipelined_adder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The ovf signal exists only when PIPE_ADD_OVF_EN is defined.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_ADD_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: a WIDTH-bit add split into STAGES carry-chained chunks,
// one chunk per pipeline stage. Each stage forwards the operand bits not yet consumed
// and the result bits already produced, so throughput is one beat per clock.
// Whole pipeline stalls together when the output is held (no bubble collapsing).
// Optional feature: define PIPE_ADD_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input logic              clk,
    input logic              rst,
    pipelined_adder_if.slave bus
);

    localparam int unsigned CHUNK = (STAGES > 0) ? WIDTH / STAGES : WIDTH;

    if ((STAGES < 1) || ((WIDTH % ((STAGES > 0) ? STAGES : 1)) != 0)) begin : g_cfg_err
        $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction is a + ~b + 1; cin is ignored in that mode.
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub ? 1'b1 : bus.cin;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned Lo = s * CHUNK;
        localparam int unsigned Hi = Lo + CHUNK;

        // a_src/b_src hold operand bits [WIDTH-1:Lo], re-based to bit 0.
        logic                v_in;
        logic                c_in;
        logic [WIDTH-Lo-1:0] a_src;
        logic [WIDTH-Lo-1:0] b_src;
        logic [CHUNK:0]      part;
        logic [Hi-1:0]       r_d;
        logic                v_q;
        logic                c_q;
        logic [Hi-1:0]       r_q;

        assign part = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, c_in};

        if (s == 0) begin : g_head
            assign v_in  = bus.in_valid;
            assign c_in  = cin_eff;
            assign a_src = bus.a;
            assign b_src = b_eff;
            assign r_d   = part[CHUNK-1:0];
        end else begin : g_tail
            assign v_in  = g_stage[s-1].v_q;
            assign c_in  = g_stage[s-1].c_q;
            assign a_src = g_stage[s-1].g_fwd.a_q;
            assign b_src = g_stage[s-1].g_fwd.b_q;
            assign r_d   = {part[CHUNK-1:0], g_stage[s-1].r_q};
        end

        // Stage valid, chunk carry and accumulated low result bits; hold on stall.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= part[CHUNK];
                r_q <= r_d;
            end
        end

        if (s < STAGES - 1) begin : g_fwd
            logic [WIDTH-Hi-1:0] a_q;
            logic [WIDTH-Hi-1:0] b_q;

            // Operand chunks still to be added by later stages.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src[WIDTH-Lo-1:CHUNK];
                    b_q <= b_src[WIDTH-Lo-1:CHUNK];
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.sum       = g_stage[STAGES-1].r_q;
    assign bus.cout      = g_stage[STAGES-1].c_q;

    // Every stage moves together whenever the output slot is empty or being taken.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

`ifdef PIPE_ADD_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB is a ^ b ^ sum at the MSB; overflow when it differs from cout.
    assign ovf_d = g_stage[STAGES-1].part[CHUNK]
                 ^ g_stage[STAGES-1].a_src[CHUNK-1]
                 ^ g_stage[STAGES-1].b_src[CHUNK-1]
                 ^ g_stage[STAGES-1].part[CHUNK-1];

    // Overflow flag travels with the final-stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: the driver pushes the reference result of each
// accepted beat, an independent monitor pops and compares on every retirement.
// Override STAGES (e.g. 1 or 32) to rerun the same sequence at other depths.
module tb_pipelined_adder;

    localparam int unsigned WIDTH = 32;
    parameter int unsigned STAGES = 4;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready has a single driver so the modes never fight.
    always @(negedge clk) begin
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact wide unsigned sum for {cout,sum}, signed range test for ovf.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        longint      full;
        longint      sres;
        logic [31:0] bop;
        int          c;
        bop  = sub ? ~b : b;
        c    = sub ? 1 : int'(cin);
        full = longint'(a) + longint'(bop) + longint'(c);
        sres = longint'($signed(a)) + longint'($signed(bop)) + longint'(c);
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        e.acc  = 0;
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input exp_t e_in);
        exp_t e;
        int   t;
        e = e_in;
        t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.sub = sub;
        #1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles", t);
            bus.in_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_exp(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic sub, input logic [31:0] s, input logic co,
                            input logic ov);
        exp_t e;
        e.sum = s;
        e.cout = co;
        e.ovf = ov;
        e.acc = 0;
        send(a, b, cin, sub, e);
    endtask

    task automatic send_rand(input int n);
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        for (int i = 0; i < n; i++) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            if (i % 7 == 3) a = 32'hFFFF_FFFF;
            if (i % 11 == 5) b = 32'h8000_0000;
            send(a, b, cin, sub, model(a, b, cin, sub));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: retire on out_valid && out_ready, verify hold while stalled.
    bit          held = 1'b0;
    bit          presenting = 1'b0;
    int          first_seen = 0;
    logic [31:0] h_sum;
    logic        h_cout;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            held = 1'b0;
            presenting = 1'b0;
        end else begin
            check("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
            if (held) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_sum", 64'(bus.sum), 64'(h_sum));
                check("hold_cout", 64'(bus.cout), 64'(h_cout));
            end
            if (bus.out_valid && !presenting) begin
                first_seen = cyc;
                presenting = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: sum=%0h with empty scoreboard", bus.sum);
                end else begin
                    e = sb.pop_front();
                    check("sum", 64'(bus.sum), 64'(e.sum));
                    check("cout", 64'(bus.cout), 64'(e.cout));
`ifdef PIPE_ADD_OVF_EN
                    check("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
                    if (lat_chk) check("latency", 64'(first_seen - e.acc), 64'(STAGES - 1));
                end
                presenting = 1'b0;
                held = 1'b0;
            end else if (bus.out_valid) begin
                held = 1'b1;
                h_sum = bus.sum;
                h_cout = bus.cout;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_sum", 64'(bus.sum), 64'd0);
        check("reset_cout", 64'(bus.cout), 64'd0);
`ifdef PIPE_ADD_OVF_EN
        check("reset_ovf", 64'(bus.ovf), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full carry ripple, then subtraction / overflow corner cases.
        lat_chk = 1'b1;
        send_exp(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        send_exp(32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_exp(32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0);
        send_exp(32'h7, 32'h5, 1'b1, 1'b1, 32'h2, 1'b1, 1'b0);
        send_exp(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send_exp(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drain();

        // Back-to-back random beats at full throughput.
        send_rand(100);
        drain();
        lat_chk = 1'b0;

        // Fill the pipeline, hold the output, then release.
        ready_mode = 0;
        fork
            send_rand(STAGES + 4);
        join_none
        repeat (STAGES + 8) @(negedge clk);
        #3;
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        ready_mode = 1;
        wait fork;
        drain();

        // Random backpressure.
        ready_mode = 2;
        send_rand(60);
        ready_mode = 1;
        drain();

        // Asynchronous reset with beats in flight.
        send_rand(STAGES + 2);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_sum", 64'(bus.sum), 64'd0);
        check("async_rst_cout", 64'(bus.cout), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * STAGES + 4) begin
            @(negedge clk);
            #3;
            check("no_stale_result", 64'(bus.out_valid), 64'd0);
        end

        send_rand(5);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
